// File: rtl/ps2_arrow_decoder_pkg.sv
// Shared PS/2 scan codes and parser state encoding for the arrow-key decoder and later PS/2 blocks.
package ps2_arrow_decoder_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Pause sends E1 followed by seven bytes that carry no make/break meaning.
  localparam logic [2:0] PauseTail = 3'd7;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StExt    = 3'd1,
    StBrk    = 3'd2,
    StExtBrk = 3'd3,
    StSkip   = 3'd4
  } ps2_state_e;

endpackage

// File: rtl/ps2_arrow_decoder_if.sv
// Byte stream from the PS/2 receiver in, steering commands and watchdog event out.
interface ps2_arrow_decoder_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       moveForward;
  logic       moveLeft;
  logic       moveRight;
  logic       timeout_evt;

  modport master (
    output rx_data, rx_valid,
    input  moveForward, moveLeft, moveRight, timeout_evt
  );

  modport slave (
    input  rx_data, rx_valid,
    output moveForward, moveLeft, moveRight, timeout_evt
  );

endinterface

// File: rtl/ps2_rx_watchdog.sv
// Idle counter for the PS/2 byte stream; flags the edge on which the idle limit is reached.
module ps2_rx_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic kick,
  input  logic armed,
  output logic fire,
  output logic expire
);

  localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // expire is only true on the single edge that moves the counter onto the limit,
  // so a saturated counter cannot fire twice in one idle period.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (kick) begin
      cnt_d = '0;
    end else if (cnt_q != Limit) begin
      cnt_d  = cnt_q + CNT_W'(1);
      expire = (cnt_d == Limit);
    end
  end

  assign fire = expire & armed;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_arrow_decoder.sv
// Decodes E0/F0 arrow-key make/break sequences into level-held steering commands.
module ps2_arrow_decoder
  import ps2_arrow_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Start,
  ps2_arrow_decoder_if.slave  ps2
);

  ps2_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       up_q, up_d, left_q, left_d, right_q, right_d;
  logic       fwd_q, lft_q, rgt_q, evt_q;
  logic       wd_fire, wd_expire;

  ps2_rx_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .Clock  (Clock),
    .Resetn (Resetn),
    .kick   (ps2.rx_valid),
    .armed  (up_q | left_q | right_q),
    .fire   (wd_fire),
    .expire (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    up_d    = up_q;
    left_d  = left_q;
    right_d = right_q;
    // An incoming byte always takes priority over the idle watchdog.
    if (ps2.rx_valid) begin
      case (state_q)
        StIdle: begin
          if (ps2.rx_data == SC_EXT) begin
            state_d = StExt;
          end else if (ps2.rx_data == SC_BRK) begin
            state_d = StBrk;
          end else if (ps2.rx_data == SC_PAUSE) begin
            state_d = StSkip;
            skip_d  = PauseTail;
          end
        end
        StExt: begin
          state_d = StIdle;
          if (ps2.rx_data == SC_BRK) begin
            state_d = StExtBrk;
          end else if (Start) begin
            if (ps2.rx_data == SC_UP)    up_d    = 1'b1;
            if (ps2.rx_data == SC_LEFT)  left_d  = 1'b1;
            if (ps2.rx_data == SC_RIGHT) right_d = 1'b1;
          end
        end
        StExtBrk: begin
          state_d = StIdle;
          if (ps2.rx_data == SC_UP)    up_d    = 1'b0;
          if (ps2.rx_data == SC_LEFT)  left_d  = 1'b0;
          if (ps2.rx_data == SC_RIGHT) right_d = 1'b0;
        end
        StSkip: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (wd_expire) begin
      state_d = StIdle;
      up_d    = 1'b0;
      left_d  = 1'b0;
      right_d = 1'b0;
    end
    if (!Start) begin
      up_d    = 1'b0;
      left_d  = 1'b0;
      right_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      skip_q  <= '0;
      up_q    <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      fwd_q   <= 1'b0;
      lft_q   <= 1'b0;
      rgt_q   <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      up_q    <= up_d;
      left_q  <= left_d;
      right_q <= right_d;
      // Gating with Start drops commands on the first edge after the game is disabled.
      fwd_q   <= Start & up_q;
      lft_q   <= Start & left_q & ~right_q;
      rgt_q   <= Start & right_q & ~left_q;
      evt_q   <= wd_fire;
    end
  end

  assign ps2.moveForward = fwd_q;
  assign ps2.moveLeft    = lft_q;
  assign ps2.moveRight   = rgt_q;
  assign ps2.timeout_evt = evt_q;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed bench for ps2_arrow_decoder with a short watchdog limit.
module tb_ps2_arrow_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  ps2_arrow_decoder_if bus ();

  ps2_arrow_decoder #(
    .TIMEOUT_CYCLES (100),
    .CNT_W          (26)
  ) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .Start  (start),
    .ps2    (bus)
  );

  always #5 clk = ~clk;

  // {moveForward, moveLeft, moveRight, timeout_evt}
  function automatic logic [3:0] outs();
    return {bus.moveForward, bus.moveLeft, bus.moveRight, bus.timeout_evt};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0000) begin
      n_bad++; $display("FAIL reset_hold: got %b want %b", outs(), 4'b0000);
    end
    rst_n = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0000) begin
      n_bad++; $display("FAIL reset_release: got %b want %b", outs(), 4'b0000);
    end
  endtask

  task automatic test_up_make_break();
    do_reset();
    send(8'hE0); send(8'h75);
    n_chk++;
    if (bus.moveForward !== 1'b0) begin
      n_bad++; $display("FAIL up_make_latency: got %b want %b", bus.moveForward, 1'b0);
    end
    @(negedge clk);
    n_chk++;
    if (outs() !== 4'b1000) begin
      n_bad++; $display("FAIL up_make: got %b want %b", outs(), 4'b1000);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    n_chk++;
    if (bus.moveForward !== 1'b1) begin
      n_bad++; $display("FAIL up_break_latency: got %b want %b", bus.moveForward, 1'b1);
    end
    @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0000) begin
      n_bad++; $display("FAIL up_break: got %b want %b", outs(), 4'b0000);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    send(8'hE0); send(8'h6B); @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0100) begin
      n_bad++; $display("FAIL left_only: got %b want %b", outs(), 4'b0100);
    end
    send(8'hE0); send(8'h74); @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0000) begin
      n_bad++; $display("FAIL left_right_conflict: got %b want %b", outs(), 4'b0000);
    end
    // Typematic repeat of a held key must not disturb anything.
    send(8'hE0); send(8'h74); @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0000) begin
      n_bad++; $display("FAIL typematic_right: got %b want %b", outs(), 4'b0000);
    end
    send(8'hE0); send(8'hF0); send(8'h74); @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0100) begin
      n_bad++; $display("FAIL right_released: got %b want %b", outs(), 4'b0100);
    end
    // Break of a key that is not held.
    send(8'hE0); send(8'hF0); send(8'h75); @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0100) begin
      n_bad++; $display("FAIL break_not_held: got %b want %b", outs(), 4'b0100);
    end
  endtask

  task automatic test_keypad();
    do_reset();
    send(8'h75); send(8'hF0); send(8'h75); repeat (2) @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0000) begin
      n_bad++; $display("FAIL keypad_ignored: got %b want %b", outs(), 4'b0000);
    end
    send(8'hE0); send(8'h74); @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0010) begin
      n_bad++; $display("FAIL keypad_resync: got %b want %b", outs(), 4'b0010);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(seq[i]);
      n_chk++;
      if (outs() !== 4'b0000) begin
        n_bad++; $display("FAIL pause_byte%0d: got %b want %b", i, outs(), 4'b0000);
      end
    end
    send(8'hE0); send(8'h6B); @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0100) begin
      n_bad++; $display("FAIL pause_then_left: got %b want %b", outs(), 4'b0100);
    end
  endtask

  // kick_at = 0 means no byte during the idle window.
  task automatic run_idle(input int kick_at, input int span, output int first_drop,
                          output int pulses, output int pulse_at);
    first_drop = 0;
    pulses     = 0;
    pulse_at   = 0;
    do_reset();
    send(8'hE0); send(8'h75);
    for (int k = 1; k <= span; k++) begin
      bus.rx_data  = 8'h00;
      bus.rx_valid = (k == kick_at);
      @(negedge clk);
      if (bus.timeout_evt === 1'b1) begin
        pulses++;
        if (pulse_at == 0) pulse_at = k;
      end
      if (k > 1 && bus.moveForward !== 1'b1 && first_drop == 0) first_drop = k;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_watchdog();
    int drop, np, pat;
    run_idle(0, 110, drop, np, pat);
    n_chk++;
    if (drop !== 100) begin
      n_bad++; $display("FAIL wd_drop_cycle: got %0d want %0d", drop, 100);
    end
    n_chk++;
    if (np !== 1) begin
      n_bad++; $display("FAIL wd_pulse_count: got %0d want %0d", np, 1);
    end
    n_chk++;
    if (pat !== 99) begin
      n_bad++; $display("FAIL wd_pulse_cycle: got %0d want %0d", pat, 99);
    end
    run_idle(99, 150, drop, np, pat);
    n_chk++;
    if (drop !== 0) begin
      n_bad++; $display("FAIL wd_kick_drop: got %0d want %0d", drop, 0);
    end
    n_chk++;
    if (np !== 0) begin
      n_bad++; $display("FAIL wd_kick_pulses: got %0d want %0d", np, 0);
    end
  endtask

  task automatic test_reset_mid_and_start();
    do_reset();
    send(8'hE0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'h75); repeat (2) @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0000) begin
      n_bad++; $display("FAIL reset_mid_seq: got %b want %b", outs(), 4'b0000);
    end
    send(8'hE0); send(8'h75); @(negedge clk);
    n_chk++;
    if (bus.moveForward !== 1'b1) begin
      n_bad++; $display("FAIL up_before_stop: got %b want %b", bus.moveForward, 1'b1);
    end
    start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.moveForward !== 1'b0) begin
      n_bad++; $display("FAIL start_off_drop: got %b want %b", bus.moveForward, 1'b0);
    end
    send(8'hE0); send(8'h75); repeat (2) @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0000) begin
      n_bad++; $display("FAIL make_while_stopped: got %b want %b", outs(), 4'b0000);
    end
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (outs() !== 4'b0000) begin
      n_bad++; $display("FAIL restart_no_stale: got %b want %b", outs(), 4'b0000);
    end
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    test_reset();
    test_up_make_break();
    test_conflict();
    test_keypad();
    test_pause();
    test_watchdog();
    test_reset_mid_and_start();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
